// File: rtl/hs_pkg.sv
// Shared handshake types for the read- and write-side stream adapters.
package hs_pkg;

  // Occupancy of a 2-entry skid buffer (0..2).
  typedef logic [1:0] bufcnt_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/hs_skid2.sv
// Two-entry circular output buffer with registered head data and valid.
module hs_skid2
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output bufcnt_t               cnt
);

  logic [DATA_WIDTH-1:0] mem   [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_n [SKID_DEPTH];
  logic                  head, head_n, tail;
  bufcnt_t               cnt_n;

  // Next-state of storage, head and count for a simultaneous push and pop.
  // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    mem_n  = mem;
    head_n = head;
    // Tail sits cnt slots past head; a 1-bit pointer wraps on its own.
    tail   = head ^ cnt[0];
    if (push) mem_n[tail] = push_data;
    if (pop)  head_n = ~head;
    cnt_n  = bufcnt_t'(cnt + bufcnt_t'(push) - bufcnt_t'(pop));
  end

  // Register the buffer and present the next head word straight from a flop.
  // NOTE: non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared too, so data reads 0 out of reset and no stale word survives.
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      head  <= 1'b0;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      mem   <= mem_n;
      head  <= head_n;
      cnt   <= cnt_n;
      data  <= mem_n[head_n];
      valid <= (cnt_n != '0);
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a one-cycle-latency FIFO read port onto a valid/ready stream.
module fifo_rd_stream
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_cnt,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic       rd_pend;
  logic       pop;
  logic [2:0] occupancy;

  assign pop       = m_valid & m_ready;
  // Buffered words plus the one still on its way from the FIFO.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, rd_pend};
  // Read only when the word is guaranteed a slot, counting the slot a pop frees this cycle.
  assign fifo_ren  = !rst && !fifo_empty && ((occupancy < 3'(SKID_DEPTH)) || pop);

  hs_skid2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend),
    .push_data(fifo_dout),
    .pop      (pop),
    .data     (m_data),
    .valid    (m_valid),
    .cnt      (buf_cnt)
  );

  // Track the in-flight read and count accepted beats (wrapping).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      rd_pend <= fifo_ren;
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural one-cycle-latency FIFO.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty, fifo_ren;
  logic [7:0] fifo_dout = 8'h00;
  logic       m_valid, m_ready = 1'b0;
  logic [7:0] m_data;
  logic [1:0] buf_cnt;
  logic [15:0] xfer_cnt;

  // Second instance with a narrow counter for the wrap check.
  logic       fifo_empty2, fifo_ren2;
  logic [7:0] fifo_dout2 = 8'h00;
  logic       m_valid2;
  logic [7:0] m_data2;
  logic [1:0] buf_cnt2;
  logic [1:0] xfer_cnt2;
  int         src2_total = 0;
  int         src2_taken = 0;

  int total = 0;
  int bad   = 0;

  logic [7:0] fmem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] recv [64];
  int         recv_n = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .buf_cnt(buf_cnt), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_ren(fifo_ren2),
    .fifo_dout(fifo_dout2), .m_valid(m_valid2), .m_ready(1'b1),
    .m_data(m_data2), .buf_cnt(buf_cnt2), .xfer_cnt(xfer_cnt2)
  );

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_empty2 = (src2_taken == src2_total);

  // Behavioural FIFO: registered dout, flushed together with the adapter.
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_ren) begin
      fifo_dout <= fmem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Counting source for the narrow-counter instance.
  always @(posedge clk) begin
    if (fifo_ren2) begin
      src2_taken <= src2_taken + 1;
      fifo_dout2 <= fifo_dout2 + 8'd1;
    end
  end

  // Every-edge invariant, underflow check and accepted-beat recorder.
  always @(posedge clk) begin
    if (!rst) begin
      total++;
      if (int'(dut.buf_cnt) + int'(dut.rd_pend) > 2) begin
        bad++;
        $display("FAIL invariant: buf_cnt+rd_pend=%0d required<=2", int'(dut.buf_cnt) + int'(dut.rd_pend));
      end
      total++;
      if (fifo_ren && fifo_empty) begin
        bad++;
        $display("FAIL underflow: fifo_ren=1 while fifo_empty=1 required no read");
      end
      if (m_valid && m_ready && recv_n < 64) begin
        recv[recv_n] = m_data;
        recv_n++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    fmem[wr_ptr % 64] = v;
    wr_ptr++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_ready = 1'b0;
    step();
    total++;
    if (fifo_ren !== 1'b0) begin bad++; $display("FAIL reset_ren: got %b want 0", fifo_ren); end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || buf_cnt !== 2'd0 || xfer_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b data=%h cnt=%0d xfer=%0d want 0/00/0/0", m_valid, m_data, buf_cnt, xfer_cnt);
    end
  endtask

  task automatic test_latency_stream;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) preload(8'h11 + 8'(i));
    #1;
    total++;
    if (fifo_ren !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL first_ren: ren=%b valid=%b want 1/0", fifo_ren, m_valid);
    end
    step();
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL lat_n1: valid=%b want 0", m_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'h11 + 8'(i)) begin
        bad++; $display("FAIL stream_%0d: valid=%b data=%h want 1/%h", i, m_valid, m_data, 8'h11 + 8'(i));
      end
    end
    step();
    total++;
    if (m_valid !== 1'b0 || xfer_cnt !== 16'd4) begin
      bad++; $display("FAIL stream_end: valid=%b xfer=%0d want 0/4", m_valid, xfer_cnt);
    end
  endtask

  task automatic test_backpressure;
    int pulses = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) preload(8'(i));
    #1;
    repeat (6) begin
      if (fifo_ren) pulses++;
      step();
    end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL bp_pulses: got %0d want 2", pulses); end
    total++;
    if (buf_cnt !== 2'd2 || m_valid !== 1'b1 || m_data !== 8'h00) begin
      bad++; $display("FAIL bp_full: cnt=%0d valid=%b data=%h want 2/1/00", buf_cnt, m_valid, m_data);
    end
    repeat (2) begin
      step();
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'h00 || fifo_ren !== 1'b0) begin
        bad++; $display("FAIL bp_stable: valid=%b data=%h ren=%b want 1/00/0", m_valid, m_data, fifo_ren);
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        bad++; $display("FAIL bp_resume_%0d: valid=%b data=%h want 1/%h", i, m_valid, m_data, 8'(i));
      end
      step();
    end
    total++;
    if (m_valid !== 1'b0 || xfer_cnt !== 16'd12) begin
      bad++; $display("FAIL bp_end: valid=%b xfer=%0d want 0/12", m_valid, xfer_cnt);
    end
  endtask

  task automatic test_toggle_ready;
    int base = recv_n;
    int cycles = 0;
    for (int i = 0; i < 16; i++) preload(8'(i));
    while ((recv_n - base) < 16 && cycles < 200) begin
      m_ready = (cycles % 2 == 0);
      step();
      cycles++;
    end
    m_ready = 1'b1;
    total++;
    if (recv_n - base != 16) begin
      bad++; $display("FAIL toggle_count: got %0d beats want 16", recv_n - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (recv[base + i] !== 8'(i)) begin
          bad++; $display("FAIL toggle_order_%0d: got %h want %h", i, recv[base + i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_empty_in_flight;
    int base;
    m_ready = 1'b1;
    repeat (3) step();
    base = recv_n;
    preload(8'hA5);
    #1;
    step();
    step();
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || fifo_ren !== 1'b0) begin
      bad++; $display("FAIL single_word: valid=%b data=%h ren=%b want 1/a5/0", m_valid, m_data, fifo_ren);
    end
    step();
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL single_drop: valid=%b want 0", m_valid); end
    repeat (3) begin
      total++;
      if (fifo_ren !== 1'b0) begin bad++; $display("FAIL single_idle_ren: got %b want 0", fifo_ren); end
      step();
    end
    total++;
    if (recv_n - base != 1 || recv[base] !== 8'hA5) begin
      bad++; $display("FAIL single_once: beats=%0d first=%h want 1/a5", recv_n - base, recv[base]);
    end
  endtask

  task automatic test_reset_mid_op;
    int base;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) preload(8'h60 + 8'(i));
    #1;
    step();
    step();
    total++;
    if (dut.buf_cnt !== 2'd1 || dut.rd_pend !== 1'b1) begin
      bad++; $display("FAIL mid_setup: cnt=%0d rd_pend=%b want 1/1", dut.buf_cnt, dut.rd_pend);
    end
    rst = 1'b1;
    #1;
    total++;
    if (fifo_ren !== 1'b0) begin bad++; $display("FAIL mid_ren: got %b want 0", fifo_ren); end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || buf_cnt !== 2'd0 || xfer_cnt !== 16'd0 || m_data !== 8'h00) begin
      bad++; $display("FAIL mid_cleared: valid=%b cnt=%0d xfer=%0d data=%h want 0/0/0/00", m_valid, buf_cnt, xfer_cnt, m_data);
    end
    base = recv_n;
    m_ready = 1'b1;
    preload(8'h3C);
    repeat (6) step();
    total++;
    if (recv_n - base != 1 || recv[base] !== 8'h3C) begin
      bad++; $display("FAIL mid_no_stale: beats=%0d first=%h want 1/3c", recv_n - base, recv[base]);
    end
  endtask

  task automatic test_counter_wrap;
    src2_total = src2_taken + 4;
    #1;
    repeat (5) step();
    total++;
    if (xfer_cnt2 !== 2'd3) begin bad++; $display("FAIL wrap_pre: got %0d want 3", xfer_cnt2); end
    step();
    total++;
    if (xfer_cnt2 !== 2'd0 || m_valid2 !== 1'b0) begin
      bad++; $display("FAIL wrap_zero: xfer=%0d valid=%b want 0/0", xfer_cnt2, m_valid2);
    end
  endtask

  initial begin
    test_reset();
    test_latency_stream();
    test_backpressure();
    test_toggle_ready();
    test_empty_in_flight();
    test_reset_mid_op();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
